matriz_carregador: RTL and testbench

Input stage of the coprocessor's matrix ALU. It receives matrix elements one byte at a time over a valid/ready stream and assembles two packed 5x5 matrices of 8-bit elements, A and B. It holds them stable on 200-bit buses that feed the element-wise ALU operators (sum and others) directly. Element i of a matrix occupies bits [i*8 +: 8], row-major, so element 0 is row 0, column 0.

---
 rtl/matriz_carregador_if.sv | 25 ++
 rtl/matriz_carregador.sv | 90 +++++++++
 tb/tb_matriz_carregador.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/matriz_carregador_if.sv
// rtl/matriz_carregador_if.sv - element stream in, packed matrices A/B out
interface matriz_carregador_if #(
   parameter int ELEM_W = 8,
   parameter int N_ELEM = 25
);
   logic                       start;
   logic                       cancel;
   logic                       in_valid;
   logic [ELEM_W-1:0]          in_data;
   logic                       in_ready;
   logic [ELEM_W*N_ELEM-1:0]   matrizA;
   logic [ELEM_W*N_ELEM-1:0]   matrizB;
   logic                       busy;
   logic                       done;

   modport master (
      output start, cancel, in_valid, in_data,
      input  in_ready, matrizA, matrizB, busy, done
   );

   modport slave (
      input  start, cancel, in_valid, in_data,
      output in_ready, matrizA, matrizB, busy, done
   );
endinterface

// File: rtl/matriz_carregador.sv
// rtl/matriz_carregador.sv - loads two 5x5 byte matrices from a valid/ready stream
// and holds them stable on packed buses for the element-wise ALU.
module matriz_carregador #(
   parameter int ELEM_W = 8,
   parameter int N_ELEM = 25
) (
   input  logic               clk,
   input  logic               rst_n,
   matriz_carregador_if.slave bus
);
   localparam int BUS_W = ELEM_W * N_ELEM;
   localparam int IDX_W = $clog2(N_ELEM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD_A = 2'd1;
   localparam logic [1:0] S_LOAD_B = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [BUS_W-1:0] r_mat_a;
   logic [BUS_W-1:0] r_mat_b;

   logic w_in_ready;
   logic w_accept;
   logic w_last;

   // Ready comes from registered state only, so it never loops back through in_valid.
   assign w_in_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_last     = (r_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_mat_a <= '0;
         r_mat_b <= '0;
      end else if (bus.cancel) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_LOAD_A;
                  r_idx   <= '0;
                  r_mat_a <= '0;
                  r_mat_b <= '0;
               end
            end
            S_LOAD_A: begin
               if (w_accept) begin
                  for (int i = 0; i < N_ELEM; i++) begin
                     if (r_idx == IDX_W'(i)) r_mat_a[i*ELEM_W +: ELEM_W] <= bus.in_data;
                  end
                  if (w_last) begin
                     r_idx   <= '0;
                     r_state <= S_LOAD_B;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            S_LOAD_B: begin
               if (w_accept) begin
                  for (int i = 0; i < N_ELEM; i++) begin
                     if (r_idx == IDX_W'(i)) r_mat_b[i*ELEM_W +: ELEM_W] <= bus.in_data;
                  end
                  if (w_last) begin
                     r_idx   <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready = w_in_ready;
   assign bus.matrizA  = r_mat_a;
   assign bus.matrizB  = r_mat_b;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_matriz_carregador.sv
// tb/tb_matriz_carregador.sv - scoreboard bench for matriz_carregador
module tb_matriz_carregador;
   logic clk;
   logic rst_n;
   int   cyc;
   int   last_start;
   int   n_cmp;
   int   n_err;

   typedef struct {
      logic [199:0] a;
      logic [199:0] b;
      logic [199:0] s;
      int           lat;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] da[25];
   logic [7:0] db[25];

   matriz_carregador_if #(.ELEM_W(8), .N_ELEM(25)) bus ();

   matriz_carregador #(.ELEM_W(8), .N_ELEM(25)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [199:0] pack_a();
      logic [199:0] v;
      for (int i = 0; i < 25; i++) v[i*8 +: 8] = da[i];
      return v;
   endfunction

   function automatic logic [199:0] pack_b(input int n);
      logic [199:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = db[i];
      return v;
   endfunction

   // Monitor: every done pulse consumes one expected load result.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
         end else begin
            exp_t         e;
            logic [199:0] s;
            e = sb.pop_front();
            for (int i = 0; i < 25; i++) s[i*8 +: 8] = bus.matrizA[i*8 +: 8] + bus.matrizB[i*8 +: 8];
            chk("done_latency", 200'(cyc - last_start), 200'(e.lat));
            chk("matrizA_at_done", bus.matrizA, e.a);
            chk("matrizB_at_done", bus.matrizB, e.b);
            chk("alu_sum_at_done", s, e.s);
            chk("busy_in_done", 200'(bus.busy), 200'(1));
            chk("ready_in_done", 200'(bus.in_ready), 200'(0));
         end
      end
   end

   task automatic run_load(input int lat, input bit bubbles, input bit stray,
                           input int cancel_at, input logic [199:0] exp_sum);
      exp_t e;
      int   k;
      int   t;
      logic rdy;
      logic v;
      if (cancel_at < 0) begin
         e.a   = pack_a();
         e.b   = pack_b(25);
         e.s   = exp_sum;
         e.lat = lat;
         sb.push_back(e);
      end
      bus.start = 1'b1;
      @(posedge clk); #1;
      last_start = cyc;
      bus.start  = stray;
      chk("clear_A_after_start", bus.matrizA, '0);
      chk("clear_B_after_start", bus.matrizB, '0);
      k = 0;
      t = 0;
      while (k < 50 && t < 200) begin
         if (cancel_at >= 0 && k == 25 + cancel_at) begin
            bus.cancel   = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hEE;
            @(posedge clk); #1;
            bus.cancel   = 1'b0;
            bus.in_valid = 1'b0;
            break;
         end
         v            = !(bubbles && (t % 3 == 2));
         bus.in_valid = v;
         bus.in_data  = (k < 25) ? da[k] : db[k-25];
         rdy          = bus.in_ready;
         @(posedge clk); #1;
         if (v && rdy) k++;
         t++;
      end
      if (t >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL load_timeout: got %0d accepted expected 50", k);
      end
      bus.in_valid = 1'b0;
      if (stray && cancel_at < 0) begin
         // DONE cycle: start and a stray element both present
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h5A;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      logic [199:0] es;
      n_cmp        = 0;
      n_err        = 0;
      last_start   = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.cancel   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 200'(bus.in_ready), 200'(0));
      chk("reset_busy", 200'(bus.busy), 200'(0));
      chk("reset_done", 200'(bus.done), 200'(0));
      chk("reset_matrizA", bus.matrizA, '0);
      chk("reset_matrizB", bus.matrizB, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of LOAD_A with idx=7
      for (int i = 0; i < 25; i++) begin
         da[i] = 8'(i + 1);
         db[i] = 8'(100 + i);
      end
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = da[k];
         @(posedge clk); #1;
      end
      chk("partial_A_before_reset", bus.matrizA, 200'h07060504030201);
      chk("busy_mid_load", 200'(bus.busy), 200'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_matrizA", bus.matrizA, '0);
      chk("async_reset_in_ready", 200'(bus.in_ready), 200'(0));
      chk("async_reset_busy", 200'(bus.busy), 200'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h33;
         chk("ready_after_reset", 200'(bus.in_ready), 200'(0));
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("no_write_after_reset", bus.matrizA, '0);

      // Streaming load: A=1..25, B=100..124, done 51 cycles after start
      for (int i = 0; i < 25; i++) es[i*8 +: 8] = 8'(101 + 2 * i);
      run_load(50, 1'b0, 1'b0, -1, es);
      chk("stream_A_elem0", 200'(bus.matrizA[7:0]), 200'(1));
      chk("stream_A_elem24", 200'(bus.matrizA[199:192]), 200'(25));
      chk("stream_B_elem0", 200'(bus.matrizB[7:0]), 200'(100));
      chk("stream_B_elem24", 200'(bus.matrizB[199:192]), 200'(124));
      @(posedge clk); #1;
      chk("idle_cycle52_busy", 200'(bus.busy), 200'(0));

      // Back-to-back, bubbles every third cycle, stray start, 8-bit wrap at element 3
      da[3] = 8'hFF;
      db[3] = 8'h37;
      es[31:24] = 8'h36;
      run_load(74, 1'b1, 1'b1, -1, es);
      chk("after_stray_busy", 200'(bus.busy), 200'(0));
      chk("stable_A_after_done", bus.matrizA, pack_a());
      chk("stable_B_after_done", bus.matrizB, pack_b(25));
      chk("wrap_A_elem3", 200'(bus.matrizA[31:24]), 200'(8'hFF));

      // in_valid while idle must not write
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h77;
         chk("idle_in_ready", 200'(bus.in_ready), 200'(0));
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("idle_no_write_A", bus.matrizA, pack_a());
      chk("idle_no_write_B", bus.matrizB, pack_b(25));

      // Cancel at LOAD_B idx=10
      da[3] = 8'd4;
      db[3] = 8'd103;
      run_load(0, 1'b0, 1'b0, 10, '0);
      chk("cancel_in_ready", 200'(bus.in_ready), 200'(0));
      chk("cancel_busy", 200'(bus.busy), 200'(0));
      chk("cancel_A_complete", bus.matrizA, pack_a());
      chk("cancel_B_partial", bus.matrizB, pack_b(10));
      chk("cancel_B_low80", 200'(bus.matrizB[79:0]), 200'(80'h6D6C6B6A696867666564));
      repeat (10) @(posedge clk);
      #1;
      chk("scoreboard_drained", 200'(sb.size()), 200'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
